// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, Status bit positions, sequencer states
// and the fixed-priority exception code selector.
package cp0_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TAKE  = 2'd1,
        S_ERET  = 2'd2,
        S_REDIR = 2'd3
    } exc_state_e;

    // Lowest set request bit wins; the caller has already checked that some bit is set.
    function automatic logic [4:0] exc_code_of(input logic [5:0] req, input logic store);
        logic [4:0] code;
        code = EXC_INT;
        if      (req[0]) code = EXC_ADEL;
        else if (req[1]) code = EXC_RI;
        else if (req[2]) code = EXC_SYS;
        else if (req[3]) code = EXC_BP;
        else if (req[4]) code = EXC_OV;
        else if (req[5]) code = store ? EXC_ADES : EXC_ADEL;
        return code;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Per-bit multi-flop synchronizer bringing asynchronous interrupt lines into clk.
// NSYNC must be at least 2.
module cp0_int_sync #(
    parameter int NSYNC = 2,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [NSYNC-1:0] sh_q;
            logic [NSYNC-1:0] sh_d;

            assign sh_d = {sh_q[NSYNC-2:0], async_in[gi]};

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sh_q <= '0;
                else          sh_q <= sh_d;
            end

            assign sync_out[gi] = sh_q[NSYNC-1];
        end
    endgenerate

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates exceptions against masked interrupts,
// strobes cp0_status, captures EPC/Cause fields and redirects fetch via ready/valid.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] VECTOR = 32'h8000_0180,
    parameter int          NSYNC  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  exc_req,
    input  logic        exc_store,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret_req,
    input  logic [5:0]  hw_int,
    input  logic [1:0]  sw_int,
    input  logic [31:0] statusreg,
    input  logic [31:0] epc_in,
    input  logic        redirect_ready,
    output logic        activeexception,
    output logic        eret,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic        cause_bd,
    output logic [4:0]  exccode,
    output logic [7:0]  cause_ip,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    logic [5:0] hw_int_sync;

    cp0_int_sync #(
        .NSYNC (NSYNC),
        .WIDTH (6)
    ) u_int_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (hw_int),
        .sync_out (hw_int_sync)
    );

    assign cause_ip = {hw_int_sync, sw_int};

    logic st_ie;
    logic st_exl;
    logic int_pend;
    logic unused_status;

    assign st_ie    = statusreg[ST_IE];
    assign st_exl   = statusreg[ST_EXL];
    assign int_pend = st_ie & ~st_exl & (|(statusreg[ST_IM_HI:ST_IM_LO] & cause_ip));
    assign unused_status = ^{statusreg[31:16], statusreg[7:2]};

    exc_state_e  state_q, state_d;
    logic        activeexception_q, activeexception_d;
    logic        eret_q, eret_d;
    logic        epc_we_q, epc_we_d;
    logic [31:0] epc_out_q, epc_out_d;
    logic        cause_bd_q, cause_bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        busy_q, busy_d;

    logic       take;
    logic [4:0] take_code;

    always_comb begin
        state_d           = state_q;
        activeexception_d = 1'b0;
        eret_d            = 1'b0;
        epc_we_d          = 1'b0;
        epc_out_d         = epc_out_q;
        cause_bd_d        = cause_bd_q;
        exccode_d         = exccode_q;
        flush_d           = 1'b0;
        redirect_valid_d  = 1'b0;
        redirect_pc_d     = redirect_pc_q;
        take              = 1'b0;
        take_code         = EXC_INT;

        unique case (state_q)
            S_IDLE: begin
                if (|exc_req) begin
                    take      = 1'b1;
                    take_code = exc_code_of(exc_req, exc_store);
                end else if (int_pend) begin
                    take      = 1'b1;
                    take_code = EXC_INT;
                end else if (eret_req && st_exl) begin
                    state_d       = S_ERET;
                    eret_d        = 1'b1;
                    flush_d       = 1'b1;
                    redirect_pc_d = epc_in;
                end else if (eret_req) begin
                    // ERET outside exception level is a reserved instruction
                    take      = 1'b1;
                    take_code = EXC_RI;
                end
            end
            S_TAKE, S_ERET: begin
                state_d          = S_REDIR;
                redirect_valid_d = 1'b1;
            end
            S_REDIR: begin
                if (redirect_ready) state_d = S_IDLE;
                else                redirect_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            state_d           = S_TAKE;
            activeexception_d = 1'b1;
            flush_d           = 1'b1;
            exccode_d         = take_code;
            redirect_pc_d     = VECTOR;
            // Nested exceptions keep the original EPC/BD
            if (!st_exl) begin
                epc_we_d   = 1'b1;
                epc_out_d  = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                cause_bd_d = exc_bd;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            activeexception_q <= 1'b0;
            eret_q            <= 1'b0;
            epc_we_q          <= 1'b0;
            epc_out_q         <= '0;
            cause_bd_q        <= 1'b0;
            exccode_q         <= '0;
            flush_q           <= 1'b0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= '0;
            busy_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            activeexception_q <= activeexception_d;
            eret_q            <= eret_d;
            epc_we_q          <= epc_we_d;
            epc_out_q         <= epc_out_d;
            cause_bd_q        <= cause_bd_d;
            exccode_q         <= exccode_d;
            flush_q           <= flush_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_pc_q     <= redirect_pc_d;
            busy_q            <= busy_d;
        end
    end

    assign activeexception = activeexception_q;
    assign eret            = eret_q;
    assign epc_we          = epc_we_q;
    assign epc_out         = epc_out_q;
    assign cause_bd        = cause_bd_q;
    assign exccode         = exccode_q;
    assign flush           = flush_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: exceptions, interrupts, ERET, nesting,
// collision, backpressure and asynchronous reset.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  exc_req;
    logic        exc_store;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret_req;
    logic [5:0]  hw_int;
    logic [1:0]  sw_int;
    logic [31:0] statusreg;
    logic [31:0] epc_in;
    logic        redirect_ready;
    logic        activeexception;
    logic        eret;
    logic        epc_we;
    logic [31:0] epc_out;
    logic        cause_bd;
    logic [4:0]  exccode;
    logic [7:0]  cause_ip;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .exc_req         (exc_req),
        .exc_store       (exc_store),
        .exc_pc          (exc_pc),
        .exc_bd          (exc_bd),
        .eret_req        (eret_req),
        .hw_int          (hw_int),
        .sw_int          (sw_int),
        .statusreg       (statusreg),
        .epc_in          (epc_in),
        .redirect_ready  (redirect_ready),
        .activeexception (activeexception),
        .eret            (eret),
        .epc_we          (epc_we),
        .epc_out         (epc_out),
        .cause_bd        (cause_bd),
        .exccode         (exccode),
        .cause_ip        (cause_ip),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .busy            (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        exc_req        = '0;
        exc_store      = 1'b0;
        exc_pc         = '0;
        exc_bd         = 1'b0;
        eret_req       = 1'b0;
        hw_int         = '0;
        sw_int         = '0;
        statusreg      = '0;
        epc_in         = '0;
        redirect_ready = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_code", 32'(exccode), 32'd0);
        chk("rst_ip", 32'(cause_ip), 32'd0);

        // Sys exception, redirect held under backpressure for one cycle
        exc_req = 6'b000100; exc_pc = 32'h0040_0020; redirect_ready = 1'b0;
        tick();
        exc_req = '0;
        chk("sys_ae", 32'(activeexception), 32'd1);
        chk("sys_code", 32'(exccode), 32'd8);
        chk("sys_epc", epc_out, 32'h0040_0020);
        chk("sys_we", 32'(epc_we), 32'd1);
        chk("sys_flush", 32'(flush), 32'd1);
        chk("sys_rv_n1", 32'(redirect_valid), 32'd0);
        chk("sys_busy", 32'(busy), 32'd1);
        tick();
        chk("sys_ae_off", 32'(activeexception), 32'd0);
        chk("sys_we_off", 32'(epc_we), 32'd0);
        chk("sys_rv", 32'(redirect_valid), 32'd1);
        chk("sys_rpc", redirect_pc, 32'h8000_0180);
        tick();
        chk("sys_rv_hold", 32'(redirect_valid), 32'd1);
        redirect_ready = 1'b1;
        tick();
        chk("sys_rv_done", 32'(redirect_valid), 32'd0);
        chk("sys_idle", 32'(busy), 32'd0);

        // Priority RI over Ov/data, delay slot EPC adjust
        exc_req = 6'b110010; exc_bd = 1'b1; exc_pc = 32'h0000_1004;
        tick();
        exc_req = '0; exc_bd = 1'b0;
        chk("pri_code", 32'(exccode), 32'd10);
        chk("pri_epc", epc_out, 32'h0000_1000);
        chk("pri_bd", 32'(cause_bd), 32'd1);
        tick(); tick();
        chk("pri_idle", 32'(busy), 32'd0);

        // Interrupt: hw_int[2] with IM[4], IE=1, EXL=0; TAKE NSYNC+1 cycles later
        statusreg = 32'h0000_1001; hw_int = 6'b000100;
        tick();
        chk("int_ip_c1", 32'(cause_ip[4]), 32'd0);
        chk("int_ae_c1", 32'(activeexception), 32'd0);
        tick();
        chk("int_ip_c2", 32'(cause_ip[4]), 32'd1);
        chk("int_ae_c2", 32'(activeexception), 32'd0);
        tick();
        chk("int_ae", 32'(activeexception), 32'd1);
        chk("int_code", 32'(exccode), 32'd0);
        statusreg = 32'h0000_1000;
        tick(); tick();
        chk("int_idle", 32'(busy), 32'd0);

        // Gated: IE=0, then EXL=1, with the line still high
        tick();
        chk("gate_ie_ae", 32'(activeexception), 32'd0);
        chk("gate_ie_busy", 32'(busy), 32'd0);
        chk("gate_ip", 32'(cause_ip[4]), 32'd1);
        statusreg = 32'h0000_1003;
        tick(); tick();
        chk("gate_exl_busy", 32'(busy), 32'd0);
        hw_int = '0; statusreg = '0; sw_int = 2'b10;
        tick(); tick();
        chk("sw_ip", 32'(cause_ip), 32'h02);

        // ERET with EXL=1
        statusreg = 32'h0000_0002; epc_in = 32'h0040_0024; eret_req = 1'b1;
        tick();
        eret_req = 1'b0;
        chk("eret_strobe", 32'(eret), 32'd1);
        chk("eret_ae", 32'(activeexception), 32'd0);
        chk("eret_flush", 32'(flush), 32'd1);
        tick();
        chk("eret_off", 32'(eret), 32'd0);
        chk("eret_rv", 32'(redirect_valid), 32'd1);
        chk("eret_rpc", redirect_pc, 32'h0040_0024);
        tick();

        // ERET with EXL=0 becomes RI
        statusreg = '0; exc_pc = 32'h0000_2000; eret_req = 1'b1;
        tick();
        eret_req = 1'b0;
        chk("eret_ri_ae", 32'(activeexception), 32'd1);
        chk("eret_ri_code", 32'(exccode), 32'd10);
        chk("eret_ri_eret", 32'(eret), 32'd0);
        tick(); tick();

        // Nested Ov with EXL=1: no EPC write
        statusreg = 32'h0000_0002; exc_req = 6'b010000; exc_pc = 32'h0000_3000;
        tick();
        exc_req = '0;
        chk("nest_ae", 32'(activeexception), 32'd1);
        chk("nest_code", 32'(exccode), 32'd12);
        chk("nest_we", 32'(epc_we), 32'd0);
        chk("nest_epc_kept", epc_out, 32'h0000_2000);
        tick(); tick();

        // Ov and ERET together: exception wins
        exc_req = 6'b010000; eret_req = 1'b1;
        tick();
        exc_req = '0; eret_req = 1'b0;
        chk("coll_ae", 32'(activeexception), 32'd1);
        chk("coll_eret", 32'(eret), 32'd0);
        tick(); tick();

        // Data store address error
        statusreg = '0; exc_req = 6'b100000; exc_store = 1'b1;
        tick();
        exc_req = '0; exc_store = 1'b0;
        chk("ades_code", 32'(exccode), 32'd5);
        tick(); tick();

        // Backpressure: valid/pc stable, further requests ignored
        redirect_ready = 1'b0; exc_req = 6'b001000; exc_pc = 32'h0050_0000;
        tick();
        chk("bp_code", 32'(exccode), 32'd9);
        exc_req = 6'b000001; eret_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_rv_%0d", i), 32'(redirect_valid), 32'd1);
            chk($sformatf("bp_rpc_%0d", i), redirect_pc, 32'h8000_0180);
            chk($sformatf("bp_ae_%0d", i), 32'(activeexception), 32'd0);
        end
        chk("bp_code_kept", 32'(exccode), 32'd9);

        // Asynchronous reset mid-REDIR
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_rv", 32'(redirect_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_rpc", redirect_pc, 32'd0);
        chk("ar_epc", epc_out, 32'd0);
        chk("ar_code", 32'(exccode), 32'd0);
        exc_req = '0; eret_req = 1'b0; redirect_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_idle", 32'(busy), 32'd0);

        // Fresh exception after reset
        exc_req = 6'b000001; exc_pc = 32'h0000_0044;
        tick();
        exc_req = '0;
        chk("post_code", 32'(exccode), 32'd4);
        chk("post_epc", epc_out, 32'h0000_0044);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
